dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared data memory (DMEM). It sits between the CPU load/store path and a DMA/loader port and owns the single DMEM port. It issues one access per grant and waits out the synchronous one-cycle read latency. It guarantees DMA forward progress with a starvation counter while otherwise giving the CPU priority.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_starve_ctr.sv | 34 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter slice.
package dmem_arb_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int WE_W           = 4;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_RESP = 2'd1,
    DMA_RESP = 2'd2
  } arb_state_t;

  // DMEM is word-addressed on the port: byte offset bits are forced to zero.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating wait counter used to bound how long DMA can be held off by the CPU.
module dmem_starve_ctr #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] ONE_V  = W'(1);
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};

  logic [W-1:0] cnt_r;

  // Count waiting cycles, stop at MAX, clear takes precedence over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= ZERO_V;
    end else if (clr) begin
      cnt_r <= ZERO_V;
    end else if (inc && (cnt_r != MAX_V)) begin
      cnt_r <= cnt_r + ONE_V;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester DMEM arbiter: CPU priority, DMA anti-starvation, one-cycle read latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WE_W-1:0]   cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [WE_W-1:0]   dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WE_W-1:0]   m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [WE_W-1:0] WE_READ = {WE_W{1'b0}};

  arb_state_t state_r;
  arb_state_t state_next_s;
  logic       at_max_s;
  logic       cpu_win_s;
  logic       dma_win_s;
  logic       starve_inc_s;
  logic       starve_clr_s;
  logic       cpu_rvalid_r;
  logic       dma_rvalid_r;

  // CPU wins a tie unless DMA has waited long enough to force its turn.
  assign cpu_win_s = cpu_req & ~(dma_req & at_max_s);
  assign dma_win_s = dma_req & ~cpu_win_s;

  // Grant, port mux and next-state decode; only IDLE issues accesses.
  always_comb begin
    state_next_s = state_r;
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    m_en         = 1'b0;
    m_addr       = {ADDR_W{1'b0}};
    m_we         = {WE_W{1'b0}};
    m_wdata      = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (cpu_win_s) begin
          cpu_gnt = 1'b1;
          m_en    = 1'b1;
          m_addr  = word_addr(cpu_addr);
          m_we    = cpu_we;
          m_wdata = cpu_wdata;
          if (cpu_we == WE_READ) begin
            state_next_s = CPU_RESP;
          end else begin
            state_next_s = IDLE;
          end
        end else if (dma_win_s) begin
          dma_gnt = 1'b1;
          m_en    = 1'b1;
          m_addr  = word_addr(dma_addr);
          m_we    = dma_we;
          m_wdata = dma_wdata;
          if (dma_we == WE_READ) begin
            state_next_s = DMA_RESP;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      CPU_RESP: state_next_s = IDLE;
      DMA_RESP: state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // State register plus rvalid flags, which mirror entry into the response states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cpu_rvalid_r <= 1'b0;
      dma_rvalid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cpu_rvalid_r <= (state_next_s == CPU_RESP);
      dma_rvalid_r <= (state_next_s == DMA_RESP);
    end
  end

  assign cpu_rvalid = cpu_rvalid_r;
  assign dma_rvalid = dma_rvalid_r;
  assign cpu_rdata  = m_rdata;
  assign dma_rdata  = m_rdata;

  // Counter runs whenever DMA is waiting, including response cycles.
  assign starve_inc_s = dma_req & ~dma_gnt;
  assign starve_clr_s = ~dma_req | dma_gnt;

  dmem_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (starve_inc_s),
    .clr     (starve_clr_s),
    .at_max  (at_max_s)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with STARVE_MAX=4.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [3:0]  dma_we;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        m_en;
  logic [31:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_we     (dma_we),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .m_en       (m_en),
    .m_addr     (m_addr),
    .m_we       (m_we),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DMEM: lane writes, registered reads one cycle after the strobe.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[128] <= 32'h1234_5678;
      m_rdata  <= 32'h0;
    end else if (m_en) begin
      if (m_we == 4'b0000) begin
        m_rdata <= mem[m_addr[9:2]];
      end else begin
        for (int l = 0; l < 4; l++)
          if (m_we[l]) mem[m_addr[9:2]][8*l +: 8] <= m_wdata[8*l +: 8];
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h40; cpu_we = 4'hF; cpu_wdata = 32'h1111_1111;
    dma_req = 1'b1; dma_addr = 32'h80; dma_we = 4'hF; dma_wdata = 32'h2222_2222;
    cycle(); cycle();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid: got %b want 0", dma_rvalid); end
    checks++; if (dut.state_r !== dmem_arb_pkg::IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state_r); end
    checks++; if (dut.u_starve.cnt_r !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut.u_starve.cnt_r); end
    reset_n = 1'b1;
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL reset_release_cpu_gnt: got %b want 1", cpu_gnt); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_release_dma_gnt: got %b want 0", dma_gnt); end
    checks++; if (m_addr !== 32'h40) begin errors++; $display("FAIL reset_release_m_addr: got %h want 00000040", m_addr); end
    cycle();
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_idle();
    cycle();
    #1;
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL idle_m_en: got %b want 0", m_en); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL idle_m_addr: got %h want 0", m_addr); end
    checks++; if (m_we !== 4'h0) begin errors++; $display("FAIL idle_m_we: got %h want 0", m_we); end
    checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL idle_m_wdata: got %h want 0", m_wdata); end
    checks++; if (dut.u_starve.cnt_r !== 3'd0) begin errors++; $display("FAIL idle_cnt: got %0d want 0", dut.u_starve.cnt_r); end
  endtask

  task automatic test_cpu_write();
    cycle();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0106; cpu_we = 4'b1100; cpu_wdata = 32'hBEEF_0000;
    #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_cpu_gnt: got %b want 1", cpu_gnt); end
    checks++; if (m_en !== 1'b1) begin errors++; $display("FAIL wr_m_en: got %b want 1", m_en); end
    checks++; if (m_addr !== 32'h0000_0104) begin errors++; $display("FAIL wr_m_addr: got %h want 00000104", m_addr); end
    checks++; if (m_we !== 4'b1100) begin errors++; $display("FAIL wr_m_we: got %b want 1100", m_we); end
    checks++; if (m_wdata !== 32'hBEEF_0000) begin errors++; $display("FAIL wr_m_wdata: got %h want beef0000", m_wdata); end
    cycle();
    cpu_addr = 32'h0000_0108; cpu_we = 4'b0011; cpu_wdata = 32'h0000_CAFE;
    #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr2_cpu_gnt: got %b want 1", cpu_gnt); end
    checks++; if (m_addr !== 32'h0000_0108) begin errors++; $display("FAIL wr2_m_addr: got %h want 00000108", m_addr); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr2_no_rvalid: got %b want 0", cpu_rvalid); end
    cycle();
    cpu_req = 1'b0;
    #2;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_end_no_rvalid: got %b want 0", cpu_rvalid); end
  endtask

  task automatic test_cpu_read();
    cycle();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0200; cpu_we = 4'b0000; cpu_wdata = 32'h0;
    #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rd_cpu_gnt_t: got %b want 1", cpu_gnt); end
    checks++; if (m_addr !== 32'h0000_0200) begin errors++; $display("FAIL rd_m_addr: got %h want 00000200", m_addr); end
    cycle();
    #1;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid_t1: got %b want 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata_t1: got %h want 12345678", cpu_rdata); end
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_t1: got %b want 0", cpu_gnt); end
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rd_m_en_t1: got %b want 0", m_en); end
    cycle();
    cpu_addr = 32'h0000_0104;
    #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rd2_gnt_t2: got %b want 1", cpu_gnt); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd2_rvalid_t2: got %b want 0", cpu_rvalid); end
    cycle();
    cpu_req = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd2_rvalid_t3: got %b want 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hBEEF_0000) begin errors++; $display("FAIL rd2_rdata_t3: got %h want beef0000", cpu_rdata); end
    cycle();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd2_rvalid_t4: got %b want 0", cpu_rvalid); end
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 6; c++) begin
      cycle();
      cpu_req = 1'b1; cpu_addr = 32'h300 + 32'(4 * c); cpu_we = 4'hF; cpu_wdata = 32'hA000_0000 + 32'(c);
      dma_req = 1'b1; dma_addr = 32'h3F0; dma_we = 4'hF; dma_wdata = 32'hD0D0_D0D0;
      #2;
      if (c < 4) begin
        checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL starve_cpu_c%0d: got cpu=%b dma=%b want cpu=1 dma=0", c, cpu_gnt, dma_gnt); end
        checks++; if (dut.u_starve.cnt_r !== 3'(c)) begin errors++; $display("FAIL starve_cnt_c%0d: got %0d want %0d", c, dut.u_starve.cnt_r, c); end
      end else if (c == 4) begin
        checks++; if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL starve_dma_c4: got cpu=%b dma=%b want cpu=0 dma=1", cpu_gnt, dma_gnt); end
        checks++; if (m_addr !== 32'h3F0) begin errors++; $display("FAIL starve_m_addr_c4: got %h want 000003f0", m_addr); end
      end else begin
        checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL starve_cpu_c5: got cpu=%b dma=%b want cpu=1 dma=0", cpu_gnt, dma_gnt); end
        checks++; if (dut.u_starve.cnt_r !== 3'd0) begin errors++; $display("FAIL starve_cnt_c5: got %0d want 0", dut.u_starve.cnt_r); end
      end
    end
    cycle();
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_read_contention();
    cycle();
    dma_req = 1'b1; dma_addr = 32'h3F0; dma_we = 4'h0;
    #2;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rc_dma_gnt_t: got %b want 1", dma_gnt); end
    cycle();
    dma_req = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h200; cpu_we = 4'h0;
    #1;
    checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL rc_dma_rvalid_t1: got %b want 1", dma_rvalid); end
    checks++; if (dma_rdata !== 32'hD0D0_D0D0) begin errors++; $display("FAIL rc_dma_rdata_t1: got %h want d0d0d0d0", dma_rdata); end
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rc_cpu_gnt_t1: got %b want 0", cpu_gnt); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rc_cpu_rvalid_t1: got %b want 0", cpu_rvalid); end
    cycle();
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rc_cpu_gnt_t2: got %b want 1", cpu_gnt); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rc_dma_rvalid_t2: got %b want 0", dma_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    cycle();
    cpu_req = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rmr_rvalid_before: got %b want 1", cpu_rvalid); end
    reset_n = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_rvalid_async: got %b want 0", cpu_rvalid); end
    checks++; if (dut.state_r !== dmem_arb_pkg::IDLE) begin errors++; $display("FAIL rmr_state: got %0d want 0", dut.state_r); end
    cycle();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_spurious_k%0d: got cpu=%b dma=%b want 0 0", k, cpu_rvalid, dma_rvalid); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = 32'h0; cpu_we = 4'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_addr = 32'h0; dma_we = 4'h0; dma_wdata = 32'h0;
    test_reset();
    test_idle();
    test_cpu_write();
    test_cpu_read();
    test_starvation();
    test_read_contention();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
